// File: rtl/fp16_pkg.sv
// Shared definitions for the 16-bit floating-point ALU stages.
// Holds field widths, the normaliser state encoding and the packed word layout.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int EXP_MAX = 31;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp16_t;

endpackage

// File: rtl/fp16_pack.sv
// Combinational packing of sign, exponent and fraction into a half-precision word.
// Overflow forces infinity; underflow forces signed zero; the flags are mutually exclusive.
module fp16_pack
    import fp16_pkg::*;
#(
    parameter int EXP_W = fp16_pkg::EXP_W,
    parameter int MAN_W = fp16_pkg::MAN_W
) (
    input  logic                   s,
    input  logic [EXP_W-1:0]       e,
    input  logic [MAN_W-1:0]       frac,
    input  logic                   ovf,
    input  logic                   unf,
    output logic [EXP_W+MAN_W:0]   word
);

    logic [EXP_W-1:0] exp_bits;
    logic [MAN_W-1:0] frac_bits;

    // Infinity sets every exponent bit; both special cases clear the fraction.
    generate
        for (genvar gi = 0; gi < EXP_W; gi++) begin : g_exp
            assign exp_bits[gi] = ovf | (e[gi] & ~unf);
        end
        for (genvar gi = 0; gi < MAN_W; gi++) begin : g_frac
            assign frac_bits[gi] = frac[gi] & ~ovf & ~unf;
        end
    endgenerate

    assign word = {s, exp_bits, frac_bits};

endmodule

// File: rtl/fp_normalize.sv
// Iterative normalise-and-pack stage: one normalisation decision per clock,
// then a registered half-precision result held on a valid/ready handshake.
module fp_normalize
    import fp16_pkg::*;
#(
    parameter int EXP_W = fp16_pkg::EXP_W,
    parameter int MAN_W = fp16_pkg::MAN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sr,
    input  logic [EXP_W-1:0]     e5,
    input  logic [MAN_W+1:0]     mf,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [EXP_W-1:0] E_MAX = '1;
    localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);

    state_t               state_reg, state_next;
    logic                 s_reg, s_next;
    logic [EXP_W-1:0]     e_reg, e_next;
    logic [MAN_W+1:0]     m_reg, m_next;
    logic                 ovf_reg, ovf_next;
    logic                 unf_reg, unf_next;
    logic [EXP_W-1:0]     e_inc;
    logic [EXP_W+MAN_W:0] pack_word;
    logic [EXP_W+MAN_W:0] result_reg;
    logic                 overflow_reg, underflow_reg, out_valid_reg;

    assign e_inc = e_reg + E_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        e_next     = e_reg;
        m_next     = m_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    s_next     = sr;
                    e_next     = e5;
                    m_next     = mf;
                    ovf_next   = 1'b0;
                    unf_next   = 1'b0;
                    state_next = NORM;
                end
            end
            NORM: begin
                if (e_reg == E_MAX) begin
                    ovf_next   = 1'b1;
                    state_next = DONE;
                end else if (m_reg == '0) begin
                    // Clearing the exponent makes the normal packing path emit signed zero.
                    e_next     = '0;
                    state_next = DONE;
                end else if (e_reg == '0) begin
                    unf_next   = 1'b1;
                    state_next = DONE;
                end else if (m_reg[MAN_W+1]) begin
                    m_next     = m_reg >> 1;
                    e_next     = e_inc;
                    ovf_next   = (e_inc == E_MAX);
                    state_next = DONE;
                end else if (m_reg[MAN_W]) begin
                    state_next = DONE;
                end else begin
                    m_next = m_reg << 1;
                    if (e_reg == E_ONE) begin
                        unf_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        e_next = e_reg - E_ONE;
                    end
                end
            end
            DONE: begin
                if (out_valid_reg && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg   <= 1'b0;
            e_reg   <= '0;
            m_reg   <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            s_reg   <= s_next;
            e_reg   <= e_next;
            m_reg   <= m_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    fp16_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_pack (
        .s    (s_reg),
        .e    (e_reg),
        .frac (m_reg[MAN_W-1:0]),
        .ovf  (ovf_reg),
        .unf  (unf_reg),
        .word (pack_word)
    );

    // The first DONE cycle registers the packed word; it is then frozen until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            if (!out_valid_reg) begin
                result_reg    <= pack_word;
                overflow_reg  <= ovf_reg;
                underflow_reg <= unf_reg;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign result    = result_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign out_valid = out_valid_reg;

endmodule
